// File: rtl/blink_pkg.sv
// -----------------------------------------------------------------------------
// blink_pkg
// Shared types and helpers for the blinker receive-side monitor.
//   blink_state_t  : monitor FSM state encoding (IDLE, ACQ, LOCKED, ERR)
//   blink_nominal  : nominal edge-to-edge interval, 2^cbits cycles
//   blink_limit    : largest in-tolerance interval, also the stall threshold
// -----------------------------------------------------------------------------
package blink_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    ERR    = 2'd3
  } blink_state_t;

  // Nominal half-period of the blinker in clock cycles.
  function automatic int unsigned blink_nominal(input int unsigned cbits);
    return 32'd1 << cbits;
  endfunction

  // Upper edge of the acceptance window; an idle line whose interval counter
  // reaches this value can no longer produce a good interval.
  function automatic int unsigned blink_limit(input int unsigned cbits,
                                              input int unsigned tol);
    return blink_nominal(cbits) + tol;
  endfunction

endpackage

// File: rtl/blink_edge_det.sv
// -----------------------------------------------------------------------------
// blink_edge_det
// Registers the monitored line once and flags any change against that copy.
// The edge flag is combinational: it is high in the very cycle the input
// differs from its registered value.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset (registered copy clears to 0)
//   d      : monitored line, synchronous to clk
//   edge_o : high in any cycle where d differs from its registered copy
// -----------------------------------------------------------------------------
module blink_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic edge_o
);

  logic d_q;

  // One-cycle delayed copy of the monitored line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign edge_o = (d != d_q);

endmodule

// File: rtl/blink_monitor.sv
// -----------------------------------------------------------------------------
// blink_monitor
// Receive-side health checker for the blinker LED output. Measures the
// interval between consecutive edges of led_in against the nominal half-period
// 2^CBITS (+/-TOL), locks after LOCK_N consecutive good intervals and reports
// an error on a bad interval or a stalled line while locked.
// Parameters:
//   CBITS  : log2 of the nominal half-period
//   TOL    : accepted deviation in cycles (0 <= TOL < 2^(CBITS-1))
//   LOCK_N : consecutive good intervals needed to lock (1..15)
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   led_in   : monitored line, synchronous to clk
//   locked   : high while the monitor is locked
//   err      : high while the monitor is in the error state
//   edge_p   : one-cycle pulse, one cycle after each detected edge
//   half_per : last measured interval in cycles, saturating
// -----------------------------------------------------------------------------
module blink_monitor
  import blink_pkg::*;
#(
  parameter int unsigned CBITS  = 13,
  parameter int unsigned TOL    = 2,
  parameter int unsigned LOCK_N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           led_in,
  output logic           locked,
  output logic           err,
  output logic           edge_p,
  output logic [CBITS:0] half_per
);

  localparam int unsigned   CW       = CBITS + 1;
  localparam int unsigned   NOM      = blink_nominal(CBITS);
  localparam int unsigned   LIM_I    = blink_limit(CBITS, TOL);
  localparam logic [CW-1:0] GOOD_LO  = CW'(NOM - TOL);
  localparam logic [CW-1:0] GOOD_HI  = CW'(LIM_I);
  localparam logic [CW-1:0] LIM      = CW'(LIM_I);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [3:0]    LOCK_TGT = 4'(LOCK_N);

  // Edge detection
  logic edge_s;

  blink_edge_det u_edge_det (
    .clk    (clk),
    .rst    (rst),
    .d      (led_in),
    .edge_o (edge_s)
  );

  // Interval counter and measurement
  logic [CW-1:0] icnt_q, icnt_d;
  logic [CW-1:0] iv_s;
  logic [CW-1:0] half_per_q, half_per_d;
  logic          edge_p_q;
  logic          good_s;
  logic          timeout_s;

  // Interval = cycles since the previous edge, inclusive of this edge cycle.
  // Saturation keeps a very long gap from wrapping into the good window.
  assign iv_s = (icnt_q == CNT_MAX) ? CNT_MAX : (icnt_q + CNT_ONE);

  assign good_s    = (iv_s >= GOOD_LO) && (iv_s <= GOOD_HI);
  // Only meaningful without an edge, so an edge and a timeout never coincide.
  assign timeout_s = (!edge_s) && (icnt_q >= LIM);

  // Next value of the interval counter and the published measurement.
  always_comb begin
    icnt_d     = icnt_q;
    half_per_d = half_per_q;
    if (edge_s) begin
      icnt_d     = CNT_ZERO;
      half_per_d = iv_s;
    end else if (icnt_q != CNT_MAX) begin
      icnt_d     = icnt_q + CNT_ONE;
      half_per_d = half_per_q;
    end else begin
      icnt_d     = icnt_q;
      half_per_d = half_per_q;
    end
  end

  // Interval counter, measurement and edge pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icnt_q     <= CNT_ZERO;
      half_per_q <= CNT_ZERO;
      edge_p_q   <= 1'b0;
    end else begin
      icnt_q     <= icnt_d;
      half_per_q <= half_per_d;
      edge_p_q   <= edge_s;
    end
  end

  // Qualification FSM
  blink_state_t state_q, state_d;
  logic [3:0]   gcnt_q, gcnt_d;
  logic [3:0]   gcnt_inc_s;
  logic         locked_q, err_q;

  assign gcnt_inc_s = gcnt_q + 4'd1;

  // Next-state logic for lock acquisition, lock maintenance and error.
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      IDLE: begin
        // First edge only opens a measurement; stalls here are expected.
        if (edge_s) begin
          state_d = ACQ;
          gcnt_d  = 4'd0;
        end else begin
          state_d = IDLE;
          gcnt_d  = gcnt_q;
        end
      end
      ACQ: begin
        if (edge_s) begin
          if (!good_s) begin
            state_d = ACQ;
            gcnt_d  = 4'd0;
          end else if (gcnt_inc_s == LOCK_TGT) begin
            state_d = LOCKED;
            gcnt_d  = gcnt_inc_s;
          end else begin
            state_d = ACQ;
            gcnt_d  = gcnt_inc_s;
          end
        end else if (timeout_s) begin
          state_d = IDLE;
          gcnt_d  = 4'd0;
        end else begin
          state_d = ACQ;
          gcnt_d  = gcnt_q;
        end
      end
      LOCKED: begin
        if ((edge_s && !good_s) || timeout_s) begin
          state_d = ERR;
          gcnt_d  = gcnt_q;
        end else begin
          state_d = LOCKED;
          gcnt_d  = gcnt_q;
        end
      end
      ERR: begin
        // The edge that ends an error is not trusted as a measurement.
        if (edge_s) begin
          state_d = ACQ;
          gcnt_d  = 4'd0;
        end else begin
          state_d = ERR;
          gcnt_d  = gcnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        gcnt_d  = 4'd0;
      end
    endcase
  end

  // State, good-interval counter and registered Moore flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gcnt_q   <= 4'd0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gcnt_q   <= gcnt_d;
      locked_q <= (state_d == LOCKED);
      err_q    <= (state_d == ERR);
    end
  end

  assign locked   = locked_q;
  assign err      = err_q;
  assign edge_p   = edge_p_q;
  assign half_per = half_per_q;

endmodule

// File: tb/tb_blink_monitor.sv
module tb_blink_monitor;

  localparam int unsigned CBITS  = 4;
  localparam int unsigned TOL    = 1;
  localparam int unsigned LOCK_N = 2;
  localparam int          SATV   = 31;

  logic           clk;
  logic           rst;
  logic           led_in;
  logic           locked;
  logic           err;
  logic           edge_p;
  logic [CBITS:0] half_per;

  int tests;
  int fails;
  int cyc;
  int last_edge;

  typedef struct {
    int         cyc;
    logic [4:0] hp;
  } exp_t;

  exp_t sb_q[$];

  blink_monitor #(
    .CBITS  (CBITS),
    .TOL    (TOL),
    .LOCK_N (LOCK_N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .led_in   (led_in),
    .locked   (locked),
    .err      (err),
    .edge_p   (edge_p),
    .half_per (half_per)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: compares each edge_p pulse and its half_per value.
  always begin
    @(posedge clk);
    #2;
    if (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
      tests++;
      fails++;
      $display("FAIL sb_missing_edge: no edge_p at cycle %0d, expected half_per %0d", sb_q[0].cyc, sb_q[0].hp);
      void'(sb_q.pop_front());
    end
    if (edge_p === 1'b1) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_edge: edge_p at cycle %0d, half_per %0d, none expected", cyc, half_per);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.cyc !== cyc || half_per !== e.hp) begin
          fails++;
          $display("FAIL sb_edge: got edge_p at cycle %0d half_per %0d, expected cycle %0d half_per %0d",
                   cyc, half_per, e.cyc, e.hp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic goto_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Toggle the line in the current cycle and schedule the expected pulse.
  task automatic toggle();
    exp_t e;
    int   d;
    d = cyc - last_edge;
    if (d > SATV) d = SATV;
    e.cyc = cyc + 1;
    e.hp  = 5'(d);
    sb_q.push_back(e);
    led_in    = ~led_in;
    last_edge = cyc;
  endtask

  task automatic release_reset();
    led_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_edge = cyc - 1;
  endtask

  task automatic test_reset_initial();
    rst    = 1'b1;
    led_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (locked !== 1'b0 || err !== 1'b0 || edge_p !== 1'b0 || half_per !== 5'd0) begin
      fails++;
      $display("FAIL reset_initial: locked=%b err=%b edge_p=%b half_per=%0d, expected all 0",
               locked, err, edge_p, half_per);
    end
    release_reset();
  endtask

  task automatic test_lock(output int e0);
    goto_cyc(cyc + 4);
    e0 = cyc;
    toggle();
    goto_cyc(e0 + 16);
    toggle();
    goto_cyc(e0 + 17);
    tests++;
    if (half_per !== 5'd16 || locked !== 1'b0) begin
      fails++;
      $display("FAIL lock_first_good: half_per=%0d locked=%b, expected 16 and 0", half_per, locked);
    end
    goto_cyc(e0 + 32);
    toggle();
    tests++;
    if (locked !== 1'b0) begin
      fails++;
      $display("FAIL lock_early: locked=%b at e0+32, expected 0", locked);
    end
    goto_cyc(e0 + 33);
    tests++;
    if (locked !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL lock_rise: locked=%b err=%b at e0+33, expected 1 and 0", locked, err);
    end
  endtask

  task automatic test_tol_high(output int e);
    e = last_edge + 17;
    goto_cyc(e);
    toggle();
    goto_cyc(e + 1);
    tests++;
    if (locked !== 1'b1 || err !== 1'b0 || half_per !== 5'd17) begin
      fails++;
      $display("FAIL tol_17: locked=%b err=%b half_per=%0d, expected 1 0 17", locked, err, half_per);
    end
  endtask

  task automatic test_stall(input int e);
    goto_cyc(e + 18);
    tests++;
    if (err !== 1'b0 || locked !== 1'b1) begin
      fails++;
      $display("FAIL stall_early: err=%b locked=%b at e+18, expected 0 and 1", err, locked);
    end
    goto_cyc(e + 19);
    tests++;
    if (err !== 1'b1 || locked !== 1'b0) begin
      fails++;
      $display("FAIL stall_err: err=%b locked=%b at e+19, expected 1 and 0", err, locked);
    end
    goto_cyc(e + 30);
    tests++;
    if (err !== 1'b1 || half_per !== 5'd17) begin
      fails++;
      $display("FAIL stall_hold: err=%b half_per=%0d at e+30, expected 1 and 17", err, half_per);
    end
  endtask

  task automatic test_recovery();
    int r0;
    r0 = cyc;
    toggle();
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL recov_err_hold: err=%b at first edge, expected 1", err);
    end
    goto_cyc(r0 + 1);
    tests++;
    if (err !== 1'b0 || locked !== 1'b0) begin
      fails++;
      $display("FAIL recov_err_drop: err=%b locked=%b, expected 0 and 0", err, locked);
    end
    goto_cyc(r0 + 16);
    toggle();
    goto_cyc(r0 + 32);
    toggle();
    tests++;
    if (locked !== 1'b0) begin
      fails++;
      $display("FAIL recov_early: locked=%b at r0+32, expected 0", locked);
    end
    goto_cyc(r0 + 33);
    tests++;
    if (locked !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL recov_lock: locked=%b err=%b at r0+33, expected 1 and 0", locked, err);
    end
  endtask

  task automatic test_tol_bad();
    int t;
    t = last_edge + 18;
    goto_cyc(t);
    toggle();
    tests++;
    if (locked !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL tol_18_same: locked=%b err=%b, expected 1 and 0", locked, err);
    end
    goto_cyc(t + 1);
    tests++;
    if (locked !== 1'b0 || err !== 1'b1 || half_per !== 5'd18) begin
      fails++;
      $display("FAIL tol_18_err: locked=%b err=%b half_per=%0d, expected 0 1 18", locked, err, half_per);
    end
  endtask

  task automatic test_reset_mid();
    goto_cyc(cyc + 3);
    rst = 1'b1;
    #1;
    tests++;
    if (locked !== 1'b0 || err !== 1'b0 || edge_p !== 1'b0 || half_per !== 5'd0) begin
      fails++;
      $display("FAIL reset_mid_async: locked=%b err=%b edge_p=%b half_per=%0d, expected all 0",
               locked, err, edge_p, half_per);
    end
    @(posedge clk);
    #1;
    release_reset();
    goto_cyc(cyc + 3);
    tests++;
    if (half_per !== 5'd0 || err !== 1'b0 || locked !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_after: half_per=%0d err=%b locked=%b, expected 0 0 0", half_per, err, locked);
    end
  endtask

  task automatic test_reset_acq();
    int a0;
    int b0;
    goto_cyc(cyc + 2);
    a0 = cyc;
    toggle();
    goto_cyc(a0 + 16);
    toggle();
    goto_cyc(a0 + 20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    release_reset();
    goto_cyc(cyc + 3);
    b0 = cyc;
    toggle();
    goto_cyc(b0 + 16);
    toggle();
    goto_cyc(b0 + 17);
    tests++;
    if (locked !== 1'b0) begin
      fails++;
      $display("FAIL reset_acq_no_lock: locked=%b after one good interval, expected 0", locked);
    end
    goto_cyc(b0 + 32);
    toggle();
    goto_cyc(b0 + 33);
    tests++;
    if (locked !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_acq_lock: locked=%b err=%b at b0+33, expected 1 and 0", locked, err);
    end
  endtask

  initial begin
    int e0;
    int e;
    tests     = 0;
    fails     = 0;
    last_edge = 0;
    test_reset_initial();
    test_lock(e0);
    test_tol_high(e);
    test_stall(e);
    test_recovery();
    test_tol_bad();
    test_reset_mid();
    test_reset_acq();
    goto_cyc(cyc + 4);
    tests++;
    if (sb_q.size() !== 0) begin
      fails++;
      $display("FAIL sb_drain: %0d expected edge pulses never seen, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/blink_monitor.md
# blink_monitor

Receive-side checker for the blinker LED output. It watches a toggling `led_in` line and measures the interval between consecutive edges against the nominal half-period of 2^CBITS cycles. It locks after a run of in-tolerance intervals and raises `err` on a bad interval or a stalled line. It sits beside the blinker in the same clock domain and is the liveness and health observer for its output.

## Interface
- `CBITS`, 13: log2 of the nominal half-period; the nominal edge-to-edge interval is 2^CBITS cycles.
- `TOL`, 2: accepted deviation in cycles, ±TOL. Constraint: 0 ≤ TOL < 2^(CBITS-1).
- `LOCK_N`, 4: consecutive good intervals required to lock. Constraint: 1 ≤ LOCK_N ≤ 15.
- `clk` in 1: the single clock; every register is clocked on its posedge.
- `rst` in 1: asynchronous, active-high reset.
- `led_in` in 1: monitored line, synchronous to `clk`.
- `locked` out 1: high while the state is LOCKED.
- `err` out 1: high while the state is ERR.
- `edge_p` out 1: one-cycle pulse, registered, for each detected edge.
- `half_per` out CBITS+1: last measured interval in cycles, saturating.

## Operation
- Edge detect:
  - `led_q` is `led_in` registered once.
  - An edge exists in a cycle when `led_in != led_q`.
- Interval counter `icnt` (CBITS+1 bits):
  - On an edge cycle it is cleared to 0.
  - Otherwise it increments, saturating at all-ones.
- Measured interval `iv = icnt + 1` on an edge cycle, saturating at 2^(CBITS+1)-1.
  - On every edge, `half_per <= iv`, including the first edge out of IDLE.
- Classification:
  - Good: 2^CBITS - TOL ≤ iv ≤ 2^CBITS + TOL.
  - Bad: any other edge interval.
  - Timeout: no edge in this cycle and `icnt >= LIM`, where LIM = 2^CBITS + TOL.
  - An edge and a timeout never coincide.
- FSM states: IDLE, ACQ, LOCKED, ERR. Good-interval counter `gcnt` is 4 bits.
- IDLE:
  - Any edge moves to ACQ with `gcnt = 0`.
  - Timeouts are ignored.
- ACQ:
  - Good edge: `gcnt + 1`. When that value equals LOCK_N, move to LOCKED.
  - Bad edge: `gcnt = 0`, stay in ACQ.
  - Timeout: move to IDLE with `gcnt = 0`.
- LOCKED:
  - Good edge: stay.
  - Bad edge or timeout: move to ERR.
- ERR:
  - Timeouts keep the state in ERR.
  - Any edge moves to ACQ with `gcnt = 0`. That edge's interval is discarded for qualification.
- Outputs are Moore and registered:
  - `locked = (state == LOCKED)`.
  - `err = (state == ERR)`.
- Reset, asynchronous:
  - State goes to IDLE.
  - `led_q`, `icnt`, `gcnt`, `half_per`, `edge_p`, `locked` and `err` all clear to 0.
  - Reset mid-operation discards all history. The first edge after release is treated as a fresh start from IDLE.

## Timing
- An edge that occurs while `led_in` changes in cycle t (comparison against `led_q`) produces `edge_p` = 1 in cycle t+1 only.
- A state change decided in cycle t is visible on `locked`/`err` in cycle t+1.
- `half_per` updates in the cycle after the edge, aligned with `edge_p`.
- Timeout latency: an edge at cycle e gives `icnt == LIM` at cycle e+LIM+1. `err` or the IDLE return is then visible at cycle e+LIM+2.
- Lock latency from IDLE: the first edge plus LOCK_N good edges. `locked` rises one cycle after the LOCK_N-th good edge.
- Steady nominal input produces no spurious `err`. Intervals exactly ±TOL from nominal are good.

## Structure
- Package `blink_pkg`:
  - `blink_state_t` enum (IDLE, ACQ, LOCKED, ERR).
  - Function `blink_nominal(CBITS)` returning 2^CBITS.
- Sub-module `blink_edge_det`:
  - Contains the `led_q` register and the edge compare.
  - Ports: `clk`, `rst`, `d`, `edge`.
- The counter, classifier and FSM live in the top module.
- Outputs carry the same liveness intent as the blinker: `led_in` toggling at nominal rate implies eventually `locked`.

## Test plan
Bench parameters: CBITS=4 (nominal 16), TOL=1, LOCK_N=2, giving LIM=17.
- Reset: `rst` high mid-simulation, `led_in` static → all outputs 0 immediately, state IDLE. `half_per` = 0 after release.
- Lock: `led_in` toggles every 16 cycles from edge e0 → `edge_p` pulses at e0+1, e0+17, e0+33. `half_per` = 16. `locked` = 1 from cycle e0+33.
- Tolerance: while LOCKED, an interval of 17 keeps `locked` = 1 with `half_per` = 17. A following interval of 18 gives `err` = 1 and `locked` = 0 the next cycle.
- Stall: LOCKED, last edge at e, then `led_in` held → `err` = 1 from cycle e+19 and stays. `half_per` is unchanged.
- Recovery: from ERR, edges every 16 cycles → the first edge moves to ACQ (`err` drops the next cycle). `locked` returns one cycle after the 2nd subsequent good edge.
- Reset mid-ACQ after one good edge → after release, an edge plus one good interval does not lock. Two good intervals are required.
